// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - shared defaults for the data SRAM responder
package data_sram_responder_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int CNT_W_DEF  = 32;
    localparam int LANES      = 4;
endpackage

// File: rtl/data_sram_responder_if.sv
// rtl/data_sram_responder_if.sv - exe-stage data SRAM access bus
interface data_sram_responder_if;
    import data_sram_responder_pkg::*;
    logic             data_sram_en;
    logic [LANES-1:0] data_sram_we;
    logic [31:0]      data_sram_addr;
    logic [31:0]      data_sram_wdata;
    logic [31:0]      data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );
    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder_sram_bank8.sv
// rtl/data_sram_responder_sram_bank8.sv - one 8-bit byte lane, combinational read, clocked write
module sram_bank8 #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout
);
    logic [7:0] mem [2**ADDR_W];

    // Read is sampled by the caller on the same edge as the write, so it sees the old byte.
    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end
endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - byte-lane data SRAM with registered read data and access counters
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_sram_responder_if.slave  bus,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      wr_cnt
);
    logic [ADDR_W-1:0] idx;
    logic [LANES-1:0]  lane_we;
    logic [31:0]       word;
    logic [31:0]       rdata;
    logic              is_rd;
    logic              is_wr;
    logic              unused_addr_bits;

    assign idx              = bus.data_sram_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.data_sram_addr[1:0], bus.data_sram_addr[31:ADDR_W+2]};
    assign is_rd            = bus.data_sram_en && (bus.data_sram_we == '0);
    assign is_wr            = bus.data_sram_en && (bus.data_sram_we != '0);

    // Gating with resetn keeps an access that coincides with reset from touching the array.
    assign lane_we = bus.data_sram_we & {LANES{bus.data_sram_en & resetn}};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sram_bank8 #(.ADDR_W(ADDR_W)) u_bank (
            .clk  (clk),
            .we   (lane_we[i]),
            .addr (idx),
            .din  (bus.data_sram_wdata[8*i +: 8]),
            .dout (word[8*i +: 8])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata  <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (bus.data_sram_en) begin
                rdata <= word;
            end
            if (is_rd && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (is_wr && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    assign bus.data_sram_rdata = rdata;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - scoreboard bench for data_sram_responder
module tb_data_sram_responder;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn;
    logic [CNT_W-1:0] rd_cnt, wr_cnt;

    data_sram_responder_if bus ();

    data_sram_responder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave),
        .rd_cnt (rd_cnt),
        .wr_cnt (wr_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [int];
    logic [31:0] m_rdata;
    bit          m_known;
    int          m_rd, m_wr;

    logic [31:0] q_rdata [$];
    bit          q_known [$];
    int          q_rd [$];
    int          q_wr [$];
    string       q_name [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic drive(input logic rstn, input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata, input string nm);
        int          w;
        logic [31:0] nw;
        @(negedge clk);
        resetn               = rstn;
        bus.data_sram_en     = en;
        bus.data_sram_we     = we;
        bus.data_sram_addr   = addr;
        bus.data_sram_wdata  = wdata;
        w = int'((addr >> 2) % (1 << ADDR_W));
        if (!rstn) begin
            m_rdata = 32'h0; m_known = 1'b1; m_rd = 0; m_wr = 0;
        end else if (en) begin
            m_known = mem.exists(w);
            m_rdata = m_known ? mem[w] : 32'h0;
            if (we != 4'h0) begin
                nw = m_rdata;
                for (int b = 0; b < 4; b++)
                    if (we[b]) nw[8*b +: 8] = wdata[8*b +: 8];
                if (m_known || we == 4'hF) mem[w] = nw;
                if (m_wr < CMAX) m_wr++;
            end else begin
                if (m_rd < CMAX) m_rd++;
            end
        end
        q_rdata.push_back(m_rdata);
        q_known.push_back(m_known);
        q_rd.push_back(m_rd);
        q_wr.push_back(m_wr);
        q_name.push_back(nm);
    endtask

    initial begin : monitor
        logic [31:0] er;
        bit          ek;
        int          erd, ewr;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (q_name.size() > 0) begin
                er = q_rdata.pop_front(); ek = q_known.pop_front();
                erd = q_rd.pop_front(); ewr = q_wr.pop_front(); nm = q_name.pop_front();
                if (ek) begin
                    n_cmp++;
                    if (bus.data_sram_rdata !== er) begin
                        n_bad++;
                        $display("FAIL %s rdata: got %h expected %h", nm, bus.data_sram_rdata, er);
                    end
                end
                n_cmp++;
                if (rd_cnt !== CNT_W'(erd)) begin
                    n_bad++;
                    $display("FAIL %s rd_cnt: got %0d expected %0d", nm, rd_cnt, erd);
                end
                n_cmp++;
                if (wr_cnt !== CNT_W'(ewr)) begin
                    n_bad++;
                    $display("FAIL %s wr_cnt: got %0d expected %0d", nm, wr_cnt, ewr);
                end
            end
        end
    end

    initial begin : stimulus
        int          pool [$];
        int          w;
        logic [31:0] a;
        logic [3:0]  we;
        resetn = 1'b0;
        bus.data_sram_en = 1'b0; bus.data_sram_we = 4'h0;
        bus.data_sram_addr = 32'h0; bus.data_sram_wdata = 32'h0;
        m_rdata = 32'h0; m_known = 1'b1; m_rd = 0; m_wr = 0;

        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "reset0");
        drive(1'b0, 1'b1, 4'hF, 32'h100, 32'h0BAD0BAD, "reset1");
        drive(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, "wr100");
        drive(1'b1, 1'b1, 4'h0, 32'h100, 32'h0, "rd100");
        drive(1'b1, 1'b1, 4'b0010, 32'h101, 32'h12121212, "wr101_lane1");
        drive(1'b1, 1'b1, 4'h0, 32'h100, 32'h0, "rd100_merged");
        drive(1'b1, 1'b1, 4'hF, 32'h40, 32'h11111111, "wr40_a");
        drive(1'b1, 1'b1, 4'hF, 32'h40, 32'h22222222, "wr40_b_readfirst");
        drive(1'b1, 1'b1, 4'h0, 32'h40, 32'h0, "rd40_new");
        drive(1'b1, 1'b1, 4'hF, 32'h0004_0008, 32'hCAFEF00D, "wr_alias");
        drive(1'b1, 1'b1, 4'h0, 32'h0000_0008, 32'h0, "rd_alias");
        drive(1'b1, 1'b1, 4'hF, 32'h200, 32'hA5A5A5A5, "wr200");
        drive(1'b1, 1'b0, 4'h0, 32'h200, 32'h0, "idle");
        drive(1'b0, 1'b1, 4'hF, 32'h200, 32'h5A5A5A5A, "reset_abort_wr");
        drive(1'b1, 1'b1, 4'h0, 32'h200, 32'h0, "rd200_after_reset");
        for (int i = 0; i < 20; i++)
            drive(1'b1, 1'b1, 4'h0, 32'h100, 32'h0, "rd_saturate");
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 4'hF, 32'h100, 32'hFFFFFFFF, "en0_hold");
        drive(1'b1, 1'b1, 4'h0, 32'h100, 32'h0, "rd100_after_en0");

        drive(1'b1, 1'b1, 4'hF, 32'h0003_FFFC, 32'h01234567, "wr_top");
        drive(1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'h89ABCDEF, "wr_low");
        pool = '{32'h40 >> 2, 32'h100 >> 2, 32'h8 >> 2, 32'h200 >> 2, 32'hFFFF, 32'h1};
        for (int i = 0; i < 400; i++) begin
            w  = pool[$urandom_range(pool.size() - 1)];
            a  = {14'($urandom), 16'(w), 2'($urandom)};
            we = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
            drive(1'b1, $urandom_range(3) != 0, we, a, $urandom, "random");
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (q_name.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q_name.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
